// File: rtl/dispense_controller.sv
// dispense_controller
//   Downstream end of the vending controller. Every cycle's vend/change code
//   is queued in a small FIFO. Entries are then played out one at a time to
//   the bottle motor and the coin ejector over four-phase req/ack handshakes,
//   so no event is lost while a mechanism is still busy.
//
// Optional feature macro: DISPENSE_TIMEOUT_EN
//   defined   : a handshake timer moves the FSM to FAULT when an ack edge
//               takes TIMEOUT cycles.
//   undefined : handshakes wait forever and fault is tied low.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   vend         bottle dispense event
//   change[1:0]  00 none, 01 one 50rs coin, 10 one 100rs coin, 11 treated as 00
//   motor_ack    bottle motor four-phase ack
//   coin_ack     coin ejector four-phase ack (shared by both tubes)
//   motor_req    bottle motor request
//   coin50_req   eject one 50rs coin
//   coin100_req  eject one 100rs coin
//   busy         FIFO non-empty or FSM not idle
//   full         FIFO holds DEPTH entries
//   overflow     sticky: an event was dropped
//   fault        sticky: handshake timeout
//   count        FIFO fill level
//   state        debug FSM state
module dispense_controller #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vend,
  input  logic [1:0]             change,
  input  logic                   motor_ack,
  input  logic                   coin_ack,
  output logic                   motor_req,
  output logic                   coin50_req,
  output logic                   coin100_req,
  output logic                   busy,
  output logic                   full,
  output logic                   overflow,
  output logic                   fault,
  output logic [$clog2(DEPTH):0] count,
  output logic [2:0]             state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dispense_controller: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << TW)) begin : g_bad_timeout
    $error("dispense_controller: TIMEOUT must be in 1..2**TW-1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOTOR     = 3'd1,
    S_MOTOR_REL = 3'd2,
    S_COIN      = 3'd3,
    S_COIN_REL  = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  typedef struct packed {
    logic       vend;
    logic [1:0] chg;
  } entry_t;

  state_t        state_q, state_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_chg_q, cur_chg_d;
  logic          motor_req_q, motor_req_d;
  logic          coin50_req_q, coin50_req_d;
  logic          coin100_req_q, coin100_req_d;
  logic          overflow_q, overflow_d;

  entry_t        in_ent, head;
  logic          ev, push, pop, fifo_full;

`ifdef DISPENSE_TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;
  logic [TW:0]   timer_inc;
  logic          fault_q, fault_d;
`endif

  // Input decode and FIFO control
  always_comb begin
    in_ent.vend = vend;
    in_ent.chg  = (change == 2'b11) ? 2'b00 : change;
    ev          = in_ent.vend | (in_ent.chg != 2'b00);
    head        = mem_q[rd_ptr_q];
    fifo_full   = (cnt_q == CW'(DEPTH));
    // Pops happen only from IDLE, so a FAULT freezes the queue head.
    pop         = (state_q == S_IDLE) && (cnt_q != '0);
    // A full FIFO still takes the push when the head leaves on the same edge.
    push        = ev && (!fifo_full || pop);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    overflow_d = overflow_q | (ev & ~push);
  end

  // FSM next state; request outputs are registered from the next state so
  // they change exactly on the edge that moves the FSM.
  always_comb begin
    state_d   = state_q;
    cur_chg_d = cur_chg_q;
    case (state_q)
      S_IDLE: if (pop) begin
        cur_chg_d = head.chg;
        state_d   = head.vend ? S_MOTOR : S_COIN;
      end
      S_MOTOR:     if (motor_ack)  state_d = S_MOTOR_REL;
      S_MOTOR_REL: if (!motor_ack) state_d = (cur_chg_q != 2'b00) ? S_COIN : S_IDLE;
      S_COIN:      if (coin_ack)   state_d = S_COIN_REL;
      S_COIN_REL:  if (!coin_ack)  state_d = S_IDLE;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_IDLE;
    endcase

`ifdef DISPENSE_TIMEOUT_EN
    // Timer runs only while a handshake state is held; any move clears it.
    timer_d   = '0;
    timer_inc = {1'b0, timer_q} + (TW+1)'(1);
    if ((state_d == state_q) &&
        (state_q inside {S_MOTOR, S_MOTOR_REL, S_COIN, S_COIN_REL})) begin
      if (timer_inc == (TW+1)'(TIMEOUT)) state_d = S_FAULT;
      else                               timer_d = timer_inc[TW-1:0];
    end
    fault_d = (state_d == S_FAULT);
`endif

    motor_req_d   = (state_d == S_MOTOR);
    coin50_req_d  = (state_d == S_COIN) && (cur_chg_d == 2'b01);
    coin100_req_d = (state_d == S_COIN) && (cur_chg_d == 2'b10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      cur_chg_q     <= '0;
      motor_req_q   <= 1'b0;
      coin50_req_q  <= 1'b0;
      coin100_req_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      cur_chg_q     <= cur_chg_d;
      motor_req_q   <= motor_req_d;
      coin50_req_q  <= coin50_req_d;
      coin100_req_q <= coin100_req_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      fault_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign motor_req   = motor_req_q;
  assign coin50_req  = coin50_req_q;
  assign coin100_req = coin100_req_q;
  assign busy        = (cnt_q != '0) || (state_q != S_IDLE);
  assign full        = fifo_full;
  assign overflow    = overflow_q;
  assign count       = cnt_q;
  assign state       = state_q;

endmodule
